// File: rtl/uart_rx_flit_os.sv
// Oversampled UART receiver: mid-bit sampling of start/data/parity/stop framing,
// packs FLIT_WIDTH/DATA_BITS characters into one flit behind a valid/ready register.
module uart_rx_flit_os #(
    parameter int FLIT_WIDTH = 32,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  uart_clk,
    input  logic                  rst,
    input  logic                  uart_rx,
    output logic [FLIT_WIDTH-1:0] flit_out,
    output logic                  flit_out_vld,
    input  logic                  flit_out_rdy,
    output logic                  framing_err,
    output logic                  parity_err,
    output logic                  overrun_err
);

    localparam int CHARS = FLIT_WIDTH / DATA_BITS;
    localparam int TW    = $clog2(OVERSAMPLE);
    localparam int BW    = $clog2(DATA_BITS);
    localparam int IW    = (CHARS > 1) ? $clog2(CHARS) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [IW-1:0] LAST_CHAR = IW'(CHARS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [IW-1:0]         idx_q;
    logic [DATA_BITS-1:0]  shift_q;
    logic [FLIT_WIDTH-1:0] asm_q, flit_next;
    logic                  rx_meta, rxs, par_flag;
    logic                  shift_en, par_sample, char_ok, frame_ev, par_ev;
    logic                  par_exp, last_char, load;

    always_ff @(posedge uart_clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge uart_clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q + 1'b1;
        bit_d      = bit_q;
        shift_en   = 1'b0;
        par_sample = 1'b0;
        char_ok    = 1'b0;
        frame_ev   = 1'b0;
        par_ev     = 1'b0;
        case (state_q)
            IDLE: begin
                tick_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                if (tick_q == TICK_MID) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_q == TICK_END) begin
                    tick_d   = '0;
                    shift_en = 1'b1;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick_q == TICK_END) begin
                    tick_d     = '0;
                    par_sample = 1'b1;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (tick_q == TICK_END) begin
                    tick_d = '0;
                    if (!rxs) begin
                        frame_ev = 1'b1;
                        bit_d    = '0;
                        state_d  = BREAK;
                    end else if (bit_q == LAST_STOP) begin
                        bit_d   = '0;
                        state_d = IDLE;
                        if (par_flag) par_ev  = 1'b1;
                        else          char_ok = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            BREAK: begin
                tick_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The final character is merged combinationally so the full flit loads on its stop-sample edge.
    always_comb begin
        flit_next = asm_q;
        flit_next[idx_q*DATA_BITS +: DATA_BITS] = shift_q;
        par_exp   = (^shift_q) ^ (PARITY_ODD != 0);
        last_char = char_ok && (idx_q == LAST_CHAR);
        load      = last_char && (!flit_out_vld || flit_out_rdy);
    end

    always_ff @(posedge uart_clk) begin
        if (rst) begin
            idx_q        <= '0;
            shift_q      <= '0;
            par_flag     <= 1'b0;
            asm_q        <= '0;
            flit_out     <= '0;
            flit_out_vld <= 1'b0;
            framing_err  <= 1'b0;
            parity_err   <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            framing_err <= frame_ev;
            parity_err  <= par_ev;
            overrun_err <= last_char && flit_out_vld && !flit_out_rdy;
            if (shift_en) shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
            if (state_q == IDLE)                par_flag <= 1'b0;
            else if (par_sample && rxs != par_exp) par_flag <= 1'b1;
            if (frame_ev || par_ev || last_char) begin
                idx_q <= '0;
            end else if (char_ok) begin
                idx_q <= idx_q + 1'b1;
                asm_q <= flit_next;
            end
            if (load) begin
                flit_out     <= flit_next;
                flit_out_vld <= 1'b1;
            end else if (flit_out_vld && flit_out_rdy) begin
                flit_out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_flit_os.sv
// Self-checking bench: an 8N1 receiver and an 8E1 receiver compared every cycle
// against a character-level model that predicts each stop-sample cycle arithmetically.
module tb_uart_rx_flit_os;

    localparam int OS = 16;
    localparam int DB = 8;
    localparam int FW = 32;

    logic          uart_clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy = 1'b1;
    logic          rx_a = 1'b1, rx_b = 1'b1;
    logic [FW-1:0] flit_a, flit_b;
    logic          vld_a, vld_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;

    always #5 uart_clk = ~uart_clk;

    uart_rx_flit_os #(.FLIT_WIDTH(FW), .DATA_BITS(DB), .OVERSAMPLE(OS),
                      .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .uart_clk(uart_clk), .rst(rst), .uart_rx(rx_a),
        .flit_out(flit_a), .flit_out_vld(vld_a), .flit_out_rdy(rdy),
        .framing_err(fe_a), .parity_err(pe_a), .overrun_err(ov_a));

    uart_rx_flit_os #(.FLIT_WIDTH(FW), .DATA_BITS(DB), .OVERSAMPLE(OS),
                      .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_b (
        .uart_clk(uart_clk), .rst(rst), .uart_rx(rx_b),
        .flit_out(flit_b), .flit_out_vld(vld_b), .flit_out_rdy(rdy),
        .framing_err(fe_b), .parity_err(pe_b), .overrun_err(ov_b));

    // kind: 0 = character stored, 1 = framing error, 2 = parity error
    typedef struct {
        int         cyc;
        int         dut;
        int         kind;
        logic [7:0] data;
    } ev_t;

    ev_t           pend[$];
    int            cyc = 0, total = 0, bad = 0;
    logic [FW-1:0] m_flit[2], m_part[2];
    bit            m_vld[2], e_fe[2], e_pe[2], e_ov[2];
    int            m_idx[2];
    int            n_rise[2], n_vcyc[2], n_fe[2], n_pe[2], n_ov[2];
    int            s_rise[2], s_vcyc[2], s_fe[2], s_pe[2], s_ov[2];
    bit            prev_v[2];
    bit            rand_rdy = 1'b0;

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: applies each character outcome on its predicted stop-sample edge.
    always @(posedge uart_clk) begin
        bit  ld[2];
        ev_t p;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            e_fe[d] = 0; e_pe[d] = 0; e_ov[d] = 0; ld[d] = 0;
        end
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_flit[d] = '0; m_part[d] = '0; m_vld[d] = 0; m_idx[d] = 0;
            end
            pend.delete();
        end else begin
            while (pend.size() > 0 && pend[0].cyc <= cyc) begin
                p = pend.pop_front();
                if (p.kind == 1) begin
                    e_fe[p.dut] = 1; m_idx[p.dut] = 0;
                end else if (p.kind == 2) begin
                    e_pe[p.dut] = 1; m_idx[p.dut] = 0;
                end else begin
                    m_part[p.dut][m_idx[p.dut]*DB +: DB] = p.data;
                    if (m_idx[p.dut] == FW/DB - 1) begin
                        m_idx[p.dut] = 0;
                        if (!m_vld[p.dut] || rdy) begin
                            m_flit[p.dut] = m_part[p.dut];
                            ld[p.dut] = 1;
                        end else begin
                            e_ov[p.dut] = 1;
                        end
                    end else begin
                        m_idx[p.dut]++;
                    end
                end
            end
            for (int d = 0; d < 2; d++) begin
                if (ld[d])                m_vld[d] = 1;
                else if (m_vld[d] && rdy) m_vld[d] = 0;
            end
        end
    end

    task automatic cmp_dut(input int d, input logic [FW-1:0] f, input logic v,
                           input logic fe, input logic pe, input logic ov);
        chk(d ? "flit_b" : "flit_a", f, m_flit[d]);
        chk(d ? "vld_b" : "vld_a", {31'b0, v}, {31'b0, m_vld[d]});
        chk(d ? "ferr_b" : "ferr_a", {31'b0, fe}, {31'b0, e_fe[d]});
        chk(d ? "perr_b" : "perr_a", {31'b0, pe}, {31'b0, e_pe[d]});
        chk(d ? "oerr_b" : "oerr_a", {31'b0, ov}, {31'b0, e_ov[d]});
        if (v === 1'b1 && !prev_v[d]) n_rise[d]++;
        if (v === 1'b1) n_vcyc[d]++;
        if (fe === 1'b1) n_fe[d]++;
        if (pe === 1'b1) n_pe[d]++;
        if (ov === 1'b1) n_ov[d]++;
        prev_v[d] = (v === 1'b1);
    endtask

    always @(negedge uart_clk) begin
        cmp_dut(0, flit_a, vld_a, fe_a, pe_a, ov_a);
        cmp_dut(1, flit_b, vld_b, fe_b, pe_b, ov_b);
    end

    always @(posedge uart_clk) begin
        if (rand_rdy) begin
            #1 rdy = 1'($urandom_range(0, 1));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge uart_clk);
        #1;
    endtask

    task automatic set_line(input int d, input logic v);
        if (d == 0) rx_a = v;
        else        rx_b = v;
    endtask

    task automatic mark();
        for (int d = 0; d < 2; d++) begin
            s_rise[d] = n_rise[d]; s_vcyc[d] = n_vcyc[d];
            s_fe[d] = n_fe[d]; s_pe[d] = n_pe[d]; s_ov[d] = n_ov[d];
        end
    endtask

    task automatic chk_counts(input string nm, input int d, input int loads, input int vcyc,
                              input int fe, input int pe, input int ov);
        chk({nm, "_loads"}, n_rise[d] - s_rise[d], loads);
        if (vcyc >= 0) chk({nm, "_vldcyc"}, n_vcyc[d] - s_vcyc[d], vcyc);
        chk({nm, "_ferr"}, n_fe[d] - s_fe[d], fe);
        chk({nm, "_perr"}, n_pe[d] - s_pe[d], pe);
        chk({nm, "_oerr"}, n_ov[d] - s_ov[d], ov);
    endtask

    // Frames one character; the stop-sample edge is 2 sync flops + 1 detect cycle
    // + half a bit to mid-start + one full bit per following bit.
    task automatic send_char(input int d, input logic [7:0] data, input bit par_bad,
                             input bit stop_bad, input int abort_bit);
        int          c0, np, nb, s, kind;
        logic [11:0] fr;
        @(posedge uart_clk);
        #1;
        c0 = cyc;
        np = (d == 1) ? 1 : 0;
        nb = 2 + DB + np;
        fr = '1;
        fr[0] = 1'b0;
        for (int i = 0; i < DB; i++) fr[1+i] = data[i];
        if (np == 1) fr[1+DB] = (^data) ^ par_bad;
        fr[nb-1] = !stop_bad;
        s = 3 + OS/2 + OS*(DB + np + 1);
        kind = stop_bad ? 1 : ((par_bad && np == 1) ? 2 : 0);
        if (abort_bit < 0) pend.push_back('{c0 + s, d, kind, data});
        for (int j = 0; j < nb; j++) begin
            set_line(d, fr[j]);
            if (j == abort_bit) begin
                idle(OS/2);
                rst = 1'b1;
                set_line(d, 1'b1);
                idle(2);
                rst = 1'b0;
                return;
            end
            idle(OS);
        end
        if (stop_bad) begin
            idle(2*OS);
            set_line(d, 1'b1);
            idle(2*OS);
        end
    endtask

    task automatic send4(input int d, input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_char(d, w[k*8 +: 8], 1'b0, 1'b0, -1);
    endtask

    initial begin
        idle(4);
        rst = 1'b0;
        @(negedge uart_clk);
        chk("rst_flit_a", flit_a, 32'h0);
        chk("rst_vld_a", {31'b0, vld_a}, 32'h0);
        chk("rst_errs_a", {29'b0, fe_a, pe_a, ov_a}, 32'h0);

        // plain 8N1 flit
        mark();
        send4(0, 32'h44332211);
        idle(40);
        chk("t1_flit", flit_a, 32'h44332211);
        chk("t1_model", m_flit[0], 32'h44332211);
        chk_counts("t1", 0, 1, 1, 0, 0, 0);

        // short glitch on an idle line
        mark();
        rx_a = 1'b0;
        idle(4);
        rx_a = 1'b1;
        idle(3*OS);
        chk_counts("t2_glitch", 0, 0, 0, 0, 0, 0);
        send4(0, 32'h8D7C6B5A);
        idle(40);
        chk("t2_flit", flit_a, 32'h8D7C6B5A);

        // framing error mid-flit then recovery from break
        mark();
        send_char(0, 8'h99, 1'b0, 1'b0, -1);
        send_char(0, 8'h77, 1'b0, 1'b1, -1);
        chk_counts("t3_brk", 0, 0, 0, 1, 0, 0);
        send4(0, 32'hDDCCBBAA);
        idle(40);
        chk("t3_flit", flit_a, 32'hDDCCBBAA);
        chk("t3_model", m_flit[0], 32'hDDCCBBAA);

        // even parity on the second receiver
        mark();
        send_char(1, 8'h01, 1'b0, 1'b0, -1);
        send_char(1, 8'hA5, 1'b1, 1'b0, -1);
        chk_counts("t4_perr", 1, 0, 0, 0, 1, 0);
        send4(1, 32'h040302A5);
        idle(40);
        chk("t4_flit", flit_b, 32'h040302A5);
        chk_counts("t4", 1, 1, -1, 0, 1, 0);

        // overrun while the consumer stalls
        rdy = 1'b0;
        mark();
        send4(0, 32'h04030201);
        send4(0, 32'h08070605);
        idle(40);
        chk("t5_flit", flit_a, 32'h04030201);
        chk("t5_vld", {31'b0, vld_a}, 32'h1);
        chk_counts("t5", 0, 1, -1, 0, 0, 1);
        @(posedge uart_clk);
        #1 rdy = 1'b1;
        @(negedge uart_clk);
        chk("t5_vld_hold", {31'b0, vld_a}, 32'h1);
        @(negedge uart_clk);
        chk("t5_vld_fall", {31'b0, vld_a}, 32'h0);
        chk("t5_flit_kept", flit_a, 32'h04030201);

        // reset during data bit 3 of the second character
        mark();
        send_char(0, 8'h55, 1'b0, 1'b0, -1);
        send_char(0, 8'h66, 1'b0, 1'b0, 4);
        @(negedge uart_clk);
        chk("t6_rst_flit_a", flit_a, 32'h0);
        chk("t6_rst_flit_b", flit_b, 32'h0);
        chk("t6_rst_out_a", {28'b0, vld_a, fe_a, pe_a, ov_a}, 32'h0);
        idle(2*OS);
        send4(0, 32'h40302010);
        idle(40);
        chk("t6_flit", flit_a, 32'h40302010);
        chk_counts("t6", 0, 1, -1, 0, 0, 0);

        // randomized traffic on both receivers with a random consumer
        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int         d;
            logic [7:0] data;
            bit         pb, sb;
            d    = int'($urandom_range(0, 1));
            data = 8'($urandom);
            pb   = (d == 1) && ($urandom_range(0, 7) == 0);
            sb   = ($urandom_range(0, 11) == 0);
            send_char(d, data, pb, sb, -1);
            idle(int'($urandom_range(0, 20)));
        end
        rand_rdy = 1'b0;
        idle(2);
        rdy = 1'b1;
        idle(200);
        chk("end_pending", pend.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
